// File: rtl/gyruss_spr_sched_if.sv
// Scheduler bus: line control, attribute RAM port and hit FIFO handshake.
// The scheduler takes the slave side; the environment/renderer the master side.
interface gyruss_spr_sched_if;
    logic       LSTRT;
    logic [8:0] SPVP;
    logic [7:0] AAD;
    logic [7:0] ADT;
    logic       HIT_VLD;
    logic       HIT_RDY;
    logic [5:0] HIT_NO;
    logic [3:0] HIT_LY;
    logic       BUSY;
    logic       LDONE;
    logic       OVFL;

    modport master (
        output LSTRT, SPVP, ADT, HIT_RDY,
        input  AAD, HIT_VLD, HIT_NO, HIT_LY, BUSY, LDONE, OVFL
    );

    modport slave (
        input  LSTRT, SPVP, ADT, HIT_RDY,
        output AAD, HIT_VLD, HIT_NO, HIT_LY, BUSY, LDONE, OVFL
    );
endinterface

// File: rtl/gyruss_spr_sched.sv
// Per-line sprite scan: walks attribute Y bytes from NSPR-1 down to 0 and
// queues {entry, line-in-sprite} for every hit in a first-word-fall-through FIFO.
module gyruss_spr_sched #(
    parameter int NSPR = 24,
    parameter int FDEP = 8
) (
    input logic               VCLKx8,
    input logic               RSTn,
    gyruss_spr_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    typedef struct packed {
        logic [5:0] no;
        logic [3:0] ly;
    } hit_t;

    localparam int         PW   = (FDEP > 2) ? $clog2(FDEP) : 1;
    localparam logic [5:0] LAST = 6'(NSPR - 1);

    state_t        state;
    logic [5:0]    idx;
    logic [8:0]    vp;
    logic [8:0]    sum;
    logic          sum_unused;
    logic          hit, full, pop, push;
    hit_t          mem [FDEP];
    hit_t          head;
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;

    // Bit 8 of the sum carries no information for the 16-line window test.
    assign sum        = {1'b0, bus.ADT} + vp;
    assign sum_unused = sum[8];
    assign hit        = (state == DATA) && (sum[7:4] == 4'hF);
    assign full       = (cnt == (PW+1)'(FDEP));
    assign pop        = bus.HIT_VLD && bus.HIT_RDY;
    // A full FIFO still takes the hit when the head leaves in the same cycle.
    assign push       = hit && (!full || pop);

    assign head        = mem[rp];
    assign bus.HIT_VLD = (cnt != '0);
    assign bus.HIT_NO  = bus.HIT_VLD ? head.no : '0;
    assign bus.HIT_LY  = bus.HIT_VLD ? head.ly : '0;

    always_ff @(posedge VCLKx8 or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            idx       <= '0;
            vp        <= '0;
            bus.AAD   <= '0;
            bus.BUSY  <= 1'b0;
            bus.LDONE <= 1'b0;
            bus.OVFL  <= 1'b0;
        end else begin
            bus.LDONE <= 1'b0;
            // Line start restarts the scan from any state, aborting a running one.
            if (bus.LSTRT) begin
                vp       <= bus.SPVP;
                idx      <= LAST;
                bus.AAD  <= {LAST, 2'd3};
                bus.BUSY <= 1'b1;
                bus.OVFL <= 1'b0;
                state    <= ADDR;
            end else begin
                case (state)
                    ADDR: state <= DATA;
                    DATA: begin
                        if (hit && full && !pop)
                            bus.OVFL <= 1'b1;
                        if (idx == '0) begin
                            bus.BUSY  <= 1'b0;
                            bus.LDONE <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx     <= idx - 6'd1;
                            bus.AAD <= {idx - 6'd1, 2'd3};
                            state   <= ADDR;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge VCLKx8 or negedge RSTn) begin
        if (!RSTn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (bus.LSTRT) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (!push && pop)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge VCLKx8) begin
        if (push && !bus.LSTRT)
            mem[wp] <= '{no: idx, ly: sum[3:0]};
    end
endmodule
